// File: rtl/gimli_din_packer.sv
// rtl/gimli_din_packer.sv - packs a framed 32-bit word stream into 128-bit Gimli input blocks
//
// Ports:
//   clk, arstn                     clock; synchronous active-low reset
//   s_data/s_size/s_last/s_oper    input word, valid bytes of a last word, end of message, core op
//   s_valid/s_ready                input word handshake
//   din/din_size/oper              packed block, its valid byte count, core op
//   din_valid/din_ready            block handshake towards the round core
module gimli_din_packer (
  input  logic         clk,
  input  logic         arstn,
  input  logic [31:0]  s_data,
  input  logic [2:0]   s_size,
  input  logic         s_last,
  input  logic [2:0]   s_oper,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] din,
  output logic [4:0]   din_size,
  output logic [2:0]   oper,
  output logic         din_valid,
  input  logic         din_ready
);

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_SEND     = 2'd1,
    ST_SEND_PAD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   blk_q, blk_d;
  logic [1:0]     widx_q, widx_d;
  logic [4:0]     bcnt_q, bcnt_d;
  logic [2:0]     oper_q, oper_d;
  logic           pad_q, pad_d;

  logic           accept;
  logic           complete;
  logic [2:0]     nbytes;
  logic [3:0]     byte_en;
  logic [31:0]    word_masked;
  logic [4:0]     bcnt_acc;

  // Byte count contributed by the incoming word; sizes above 4 saturate.
  always_comb begin
    nbytes = 3'd4;
    if (s_last && (s_size < 3'd4)) begin
      nbytes = s_size;
    end
    case (nbytes)
      3'd0:    byte_en = 4'b0000;
      3'd1:    byte_en = 4'b0001;
      3'd2:    byte_en = 4'b0011;
      3'd3:    byte_en = 4'b0111;
      default: byte_en = 4'b1111;
    endcase
    word_masked = '0;
    for (int i = 0; i < 4; i++) begin
      word_masked[8*i +: 8] = byte_en[i] ? s_data[8*i +: 8] : 8'h00;
    end
  end

  assign accept   = s_valid && (state_q == ST_FILL);
  assign complete = accept && ((widx_q == 2'd3) || s_last);
  assign bcnt_acc = bcnt_q + {2'b00, nbytes};

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q <= ST_FILL;
      blk_q   <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      oper_q  <= '0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      oper_q  <= oper_d;
      pad_q   <= pad_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (complete) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (din_ready) begin
          state_d = pad_q ? ST_SEND_PAD : ST_FILL;
        end
      end
      ST_SEND_PAD: begin
        if (din_ready) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Datapath next-state: the buffer is zeroed whenever FILL is re-entered so
  // words never written in a short block read back as zero.
  always_comb begin
    blk_d  = blk_q;
    widx_d = widx_q;
    bcnt_d = bcnt_q;
    oper_d = oper_q;
    pad_d  = pad_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          blk_d[{widx_q, 5'd0} +: 32] = word_masked;
          bcnt_d = bcnt_acc;
          if (widx_q == 2'd0) begin
            oper_d = s_oper;
          end
          if (complete) begin
            // A message ending exactly on a block boundary still owes Gimli an empty block.
            pad_d = s_last && (bcnt_acc == 5'd16);
          end else begin
            widx_d = widx_q + 2'd1;
          end
        end
      end
      ST_SEND: begin
        if (din_ready && !pad_q) begin
          blk_d  = '0;
          widx_d = '0;
          bcnt_d = '0;
        end
      end
      ST_SEND_PAD: begin
        if (din_ready) begin
          pad_d  = 1'b0;
          blk_d  = '0;
          widx_d = '0;
          bcnt_d = '0;
        end
      end
      default: begin
        pad_d = 1'b0;
      end
    endcase
  end

  // Outputs decode from state only; nothing passes combinationally between the two handshakes.
  always_comb begin
    s_ready   = arstn && (state_q == ST_FILL);
    din_valid = (state_q == ST_SEND) || (state_q == ST_SEND_PAD);
    din       = (state_q == ST_SEND) ? blk_q : '0;
    din_size  = (state_q == ST_SEND) ? bcnt_q : '0;
    oper      = oper_q;
  end

endmodule

// File: tb/tb_gimli_din_packer.sv
// tb/tb_gimli_din_packer.sv - self-checking bench for gimli_din_packer
module tb_gimli_din_packer;

  logic         clk = 1'b0;
  logic         arstn;
  logic [31:0]  s_data;
  logic [2:0]   s_size;
  logic         s_last;
  logic [2:0]   s_oper;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] din;
  logic [4:0]   din_size;
  logic [2:0]   oper;
  logic         din_valid;
  logic         din_ready;

  gimli_din_packer dut (
    .clk       (clk),
    .arstn     (arstn),
    .s_data    (s_data),
    .s_size    (s_size),
    .s_last    (s_last),
    .s_oper    (s_oper),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .din       (din),
    .din_size  (din_size),
    .oper      (oper),
    .din_valid (din_valid),
    .din_ready (din_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [4:0]   sz;
    logic [2:0]   op;
  } blk_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cnt = 0;
  bit rnd_ready = 0;

  blk_t        exp_q[$];
  int          hs_cyc[$];
  logic [31:0] msg_w[$];
  logic [2:0]  msg_op[$];

  bit           pv = 0;
  bit           phs = 0;
  logic [127:0] pd;
  logic [4:0]   psz;
  logic [2:0]   pop;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected blocks from a message: words are grouped four per block, the
  // bytes of each block laid out little-endian, a block's op is that of its
  // first word, and a final 16-byte block is followed by an empty one.
  task automatic model(input int lsz);
    int nw;
    int eff;
    blk_t b;
    nw  = msg_w.size();
    eff = (lsz > 4) ? 4 : lsz;
    for (int bi = 0; bi * 4 < nw; bi++) begin
      b.d  = '0;
      b.sz = '0;
      b.op = msg_op[bi*4];
      for (int k = 0; k < 4; k++) begin
        int idx;
        int n;
        idx = bi * 4 + k;
        if (idx < nw) begin
          n = (idx == nw - 1) ? eff : 4;
          for (int j = 0; j < n; j++) begin
            b.d[8*(4*k+j) +: 8] = msg_w[idx][8*j +: 8];
          end
          b.sz = b.sz + 5'(n);
        end
      end
      exp_q.push_back(b);
      if ((bi * 4 + 4 >= nw) && (b.sz == 5'd16)) begin
        blk_t p;
        p.d  = '0;
        p.sz = '0;
        p.op = b.op;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic tick(output bit acc);
    bit hs;
    if (hold_cnt > 0 && din_valid) begin
      din_ready = 1'b0;
      hold_cnt--;
      chk("hold_s_ready", {127'b0, s_ready}, 128'd0);
    end else begin
      din_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    @(negedge clk);
    acc = s_valid && s_ready;
    hs  = din_valid && din_ready;
    if (arstn) begin
      chk("ready_xor_valid", {127'b0, s_ready ^ din_valid}, 128'd1);
      if (pv && !phs) begin
        chk("stable_valid", {127'b0, din_valid}, 128'd1);
        chk("stable_din", din, pd);
        chk("stable_size", {123'b0, din_size}, {123'b0, psz});
        chk("stable_oper", {125'b0, oper}, {125'b0, pop});
      end
      if (hs) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_block", din, 128'hx);
        end else begin
          blk_t e;
          e = exp_q.pop_front();
          chk("blk_din", din, e.d);
          chk("blk_size", {123'b0, din_size}, {123'b0, e.sz});
          chk("blk_oper", {125'b0, oper}, {125'b0, e.op});
        end
      end
      pv = din_valid;
    end else begin
      pv = 1'b0;
      chk("reset_s_ready", {127'b0, s_ready}, 128'd0);
    end
    phs = hs;
    pd  = din;
    psz = din_size;
    pop = oper;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gen(input int nw, input logic [2:0] op0);
    msg_w.delete();
    msg_op.delete();
    for (int i = 0; i < nw; i++) begin
      msg_w.push_back($urandom);
      msg_op.push_back((i == 0) ? op0 : 3'($urandom_range(0, 2)));
    end
  endtask

  task automatic send_msg(input int lsz);
    bit acc;
    int guard;
    model(lsz);
    for (int i = 0; i < msg_w.size(); i++) begin
      s_valid = 1'b1;
      s_data  = msg_w[i];
      s_last  = (i == msg_w.size() - 1);
      s_size  = s_last ? 3'(lsz) : 3'($urandom_range(0, 7));
      s_oper  = msg_op[i];
      guard   = 0;
      acc     = 0;
      while (!acc && guard < 200) begin
        tick(acc);
        guard++;
      end
      if (!acc) chk("accept_timeout", 128'd0, 128'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      tick(acc);
      guard++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'd0);
    tick(acc);
    tick(acc);
  endtask

  initial begin
    bit acc;
    arstn = 1'b0; s_valid = 1'b0; s_data = '0; s_size = '0;
    s_last = 1'b0; s_oper = '0; din_ready = 1'b0;

    // reset state
    tick(acc);
    tick(acc);
    arstn = 1'b1;
    tick(acc);
    chk("rst_s_ready", {127'b0, s_ready}, 128'd1);
    chk("rst_din_valid", {127'b0, din_valid}, 128'd0);
    chk("rst_din", din, 128'd0);
    chk("rst_din_size", {123'b0, din_size}, 128'd0);
    chk("rst_oper", {125'b0, oper}, 128'd0);

    // 16-byte message: full block then empty pad block
    msg_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    msg_op = '{3'b001, 3'b000, 3'b010, 3'b000};
    send_msg(4);
    drain();

    // 6-byte message
    msg_w = '{32'h44332211, 32'hAABB6655};
    msg_op = '{3'b010, 3'b001};
    send_msg(2);
    drain();

    // empty message, s_ready back afterwards
    msg_w = '{32'hDEADBEEF};
    msg_op = '{3'b001};
    send_msg(0);
    drain();
    chk("empty_then_ready", {127'b0, s_ready}, 128'd1);

    // 4th word last with short size: 12..15 bytes, no pad
    gen(4, 3'b000);
    send_msg(3);
    drain();

    // 20-byte message with the first block held 10 cycles
    hold_cnt = 10;
    gen(5, 3'b010);
    send_msg(4);
    drain();
    chk("hold_consumed", 128'(hold_cnt), 128'd0);

    // reset with two words buffered discards them
    s_valid = 1'b1; s_last = 1'b0; s_oper = 3'b001;
    s_data = 32'h11111111; tick(acc);
    s_data = 32'h22222222; tick(acc);
    s_valid = 1'b0;
    arstn = 1'b0; tick(acc);
    arstn = 1'b1; tick(acc);
    chk("rst_mid_valid", {127'b0, din_valid}, 128'd0);
    gen(4, 3'b001);
    send_msg(4);
    drain();

    // back-to-back 15-byte messages: one block every 5 cycles
    hs_cyc.delete();
    gen(4, 3'b000);
    send_msg(3);
    gen(4, 3'b010);
    send_msg(3);
    drain();
    chk("thruput_blocks", 128'(hs_cyc.size()), 128'd2);
    if (hs_cyc.size() >= 2) chk("thruput_gap", 128'(hs_cyc[1] - hs_cyc[0]), 128'd5);

    // randomized messages with random back-pressure
    rnd_ready = 1;
    for (int m = 0; m < 40; m++) begin
      gen($urandom_range(1, 9), 3'($urandom_range(0, 2)));
      send_msg($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
